// File: rtl/rad_async_fifo_ptr_sync_mc.sv
// Purpose: brings NCH foreign-domain Gray pointers into clk through STAGES-deep flop chains, registers binary, flags changes and optional illegal steps.
// Latency: STAGES-1 edges after capture to q_gray, STAGES edges after capture to q_bin/chg; q_vld after STAGES+1 edges out of reset.
// Backpressure: none; every input is sampled every cycle. Step checker compiled only with RAD_ASYNC_FIFO_PTR_SYNC_CHECK_EN defined.
module rad_async_fifo_ptr_sync_mc #(
    parameter int   ADDRSIZE = 3,
    parameter int   NCH      = 1,
    parameter int   STAGES   = 2,
    parameter logic RESET    = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCH*(ADDRSIZE+1)-1:0]   d_gray,
    input  logic                          err_clr,
    output logic [NCH*(ADDRSIZE+1)-1:0]   q_gray,
    output logic [NCH*(ADDRSIZE+1)-1:0]   q_bin,
    output logic                          q_vld,
    output logic [NCH-1:0]                chg,
    output logic [NCH-1:0]                gray_err
);

    localparam int W   = ADDRSIZE + 1;
    localparam int NW  = NCH * W;
    localparam int WCW = $clog2(STAGES + 2);
    localparam logic [WCW-1:0] WMAX = WCW'(STAGES + 1);

    // Prefix XOR from the MSB down.
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [NW-1:0] gray2bin_all(input logic [NW-1:0] g);
        logic [NW-1:0] b;
        for (int c = 0; c < NCH; c++) begin
            b[c*W +: W] = gray2bin(g[c*W +: W]);
        end
        return b;
    endfunction

    localparam logic [NW-1:0] RST_GRAY = {NW{RESET}};
    localparam logic [NW-1:0] RST_BIN  = gray2bin_all(RST_GRAY);

    logic [NW-1:0]  sync_q [STAGES];
    logic [NW-1:0]  bin_q, bin_d;
    logic [NW-1:0]  prev_q;
    logic [NCH-1:0] chg_q, chg_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           vld_q;

    // Bare flop chain per bit; nothing sits between stages apart from the reset load.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= RST_GRAY;
            end
        end else begin
            sync_q[0] <= d_gray;
            for (int s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign q_gray = sync_q[STAGES-1];

    // Next-state: saturating warm-up count, binary conversion, per-channel change detect masked until warm.
    always_comb begin
        wcnt_d = (wcnt_q == WMAX) ? wcnt_q : wcnt_q + WCW'(1);
        bin_d  = gray2bin_all(q_gray);
        chg_d  = '0;
        for (int c = 0; c < NCH; c++) begin
            chg_d[c] = vld_q && (q_gray[c*W +: W] != prev_q[c*W +: W]);
        end
    end

    // Output and bookkeeping registers; prev_q tracks the Gray value behind the current bin_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
            vld_q  <= 1'b0;
            bin_q  <= RST_BIN;
            prev_q <= RST_GRAY;
            chg_q  <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            vld_q  <= (wcnt_d == WMAX);
            bin_q  <= bin_d;
            prev_q <= q_gray;
            chg_q  <= chg_d;
        end
    end

    assign q_bin = bin_q;
    assign q_vld = vld_q;
    assign chg   = chg_q;

`ifdef RAD_ASYNC_FIFO_PTR_SYNC_CHECK_EN
    logic [NCH-1:0] err_q, err_d;

    // Sticky multi-bit-step flag; a new violation outranks a clear in the same cycle.
    always_comb begin
        err_d = err_q & ~{NCH{err_clr}};
        for (int c = 0; c < NCH; c++) begin
            if (vld_q && ($countones(q_gray[c*W +: W] ^ prev_q[c*W +: W]) > 1)) begin
                err_d[c] = 1'b1;
            end
        end
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign gray_err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign gray_err       = '0;
`endif

endmodule

// File: tb/tb_rad_async_fifo_ptr_sync_mc.sv
// Purpose: self-checking bench for rad_async_fifo_ptr_sync_mc (ADDRSIZE=3, NCH=2, STAGES=2, RESET=0).
// Latency: expected binary values queued at drive time, popped when chg pulses.
// Backpressure: not applicable; stimulus is cycle-driven.
module tb_rad_async_fifo_ptr_sync_mc;

    logic       clk;
    logic       rst;
    logic       err_clr;
    logic [7:0] d_gray;
    logic [7:0] q_gray;
    logic [7:0] q_bin;
    logic       q_vld;
    logic [1:0] chg;
    logic [1:0] gray_err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];

`ifdef RAD_ASYNC_FIFO_PTR_SYNC_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    rad_async_fifo_ptr_sync_mc #(
        .ADDRSIZE(3),
        .NCH     (2),
        .STAGES  (2),
        .RESET   (1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d_gray  (d_gray),
        .err_clr (err_clr),
        .q_gray  (q_gray),
        .q_bin   (q_bin),
        .q_vld   (q_vld),
        .chg     (chg),
        .gray_err(gray_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if ({q_gray, q_bin, chg, gray_err, q_vld} !== 21'd0)
                $display("FAIL reset_outputs cyc=%0d got q_gray=%h q_bin=%h chg=%b err=%b vld=%b want all 0",
                         i, q_gray, q_bin, chg, gray_err, q_vld);
            else n_pass++;
        end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_chk++;
            if (q_vld !== (i == 3) || chg !== 2'b00)
                $display("FAIL warmup edge=%0d got vld=%b chg=%b want vld=%b chg=00", i, q_vld, chg, (i == 3));
            else n_pass++;
        end
    endtask

    task automatic test_latency;
        logic [3:0] e;
        d_gray[3:0] = 4'b0001;
        exp_q0.push_back(4'd1);
        tick();
        tick();
        n_chk++;
        if (q_gray[3:0] !== 4'b0001 || chg !== 2'b00)
            $display("FAIL latency_qgray got q_gray0=%b chg=%b want 0001 00", q_gray[3:0], chg);
        else n_pass++;
        tick();
        n_chk++;
        if (chg !== 2'b01) $display("FAIL latency_chg got %b want 01", chg);
        else n_pass++;
        n_chk++;
        e = exp_q0.pop_front();
        if (q_bin[3:0] !== e) $display("FAIL latency_qbin got %0d want %0d", q_bin[3:0], e);
        else n_pass++;
        tick();
        n_chk++;
        if (chg !== 2'b00) $display("FAIL latency_chg_low got %b want 00", chg);
        else n_pass++;
    endtask

    task automatic test_wrap;
        int         pulses;
        logic [3:0] b;
        logic [3:0] e;
        pulses = 0;
        for (int n = 1; n <= 16; n++) begin
            b = 4'(n + 1);
            d_gray[3:0] = to_gray(b);
            exp_q0.push_back(b);
            for (int t = 0; t < 3; t++) begin
                tick();
                if (chg[0]) begin
                    pulses++;
                    n_chk++;
                    if (exp_q0.size() == 0) $display("FAIL wrap_unexpected_chg0 q_bin0=%0d", q_bin[3:0]);
                    else begin
                        e = exp_q0.pop_front();
                        if (q_bin[3:0] !== e) $display("FAIL wrap_qbin got %0d want %0d", q_bin[3:0], e);
                        else n_pass++;
                    end
                end
                n_chk++;
                if (chg[1] !== 1'b0 || gray_err !== 2'b00)
                    $display("FAIL wrap_side got chg1=%b err=%b want 0 00", chg[1], gray_err);
                else n_pass++;
            end
        end
        n_chk++;
        if (pulses != 16) $display("FAIL wrap_pulse_count got %0d want 16", pulses);
        else n_pass++;
    endtask

    task automatic test_illegal;
        logic [3:0] e;
        d_gray[7:4] = 4'b0011;
        exp_q1.push_back(4'd2);
        tick(); tick(); tick();
        n_chk++;
        if (chg !== 2'b10 || gray_err !== {CHK, 1'b0})
            $display("FAIL illegal_set got chg=%b err=%b want 10 %b0", chg, gray_err, CHK);
        else n_pass++;
        n_chk++;
        e = exp_q1.pop_front();
        if (q_bin[7:4] !== e) $display("FAIL illegal_qbin1 got %0d want %0d", q_bin[7:4], e);
        else n_pass++;
        tick(); tick();
        n_chk++;
        if (chg !== 2'b00 || gray_err !== {CHK, 1'b0})
            $display("FAIL illegal_sticky got chg=%b err=%b want 00 %b0", chg, gray_err, CHK);
        else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_chk++;
        if (gray_err !== 2'b00) $display("FAIL illegal_clear got %b want 00", gray_err);
        else n_pass++;
        d_gray[7:4] = 4'b0101;
        exp_q1.push_back(4'd6);
        tick(); tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_chk++;
        if (chg !== 2'b10 || gray_err !== {CHK, 1'b0})
            $display("FAIL illegal_set_wins got chg=%b err=%b want 10 %b0", chg, gray_err, CHK);
        else n_pass++;
        n_chk++;
        e = exp_q1.pop_front();
        if (q_bin[7:4] !== e) $display("FAIL illegal_qbin1b got %0d want %0d", q_bin[7:4], e);
        else n_pass++;
        tick();
        n_chk++;
        if (gray_err !== {CHK, 1'b0}) $display("FAIL illegal_sticky2 got %b want %b0", gray_err, CHK);
        else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_chk++;
        if (gray_err !== 2'b00) $display("FAIL illegal_clear2 got %b want 00", gray_err);
        else n_pass++;
    endtask

    // Back-to-back single steps on ch0 up to 9, then reset mid-flight and re-warm.
    task automatic test_mid_reset;
        logic [3:0] e;
        for (int n = 2; n <= 12; n++) begin
            if (n <= 9) begin
                d_gray[3:0] = to_gray(4'(n));
                exp_q0.push_back(4'(n));
            end
            tick();
            if (chg[0]) begin
                n_chk++;
                if (exp_q0.size() == 0) $display("FAIL b2b_unexpected_chg0 q_bin0=%0d", q_bin[3:0]);
                else begin
                    e = exp_q0.pop_front();
                    if (q_bin[3:0] !== e) $display("FAIL b2b_qbin got %0d want %0d", q_bin[3:0], e);
                    else n_pass++;
                end
            end
        end
        n_chk++;
        if (exp_q0.size() != 0 || q_bin[3:0] !== 4'd9 || q_vld !== 1'b1)
            $display("FAIL b2b_final got left=%0d q_bin0=%0d vld=%b want 0 9 1", exp_q0.size(), q_bin[3:0], q_vld);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if ({q_gray, q_bin, chg, gray_err, q_vld} !== 21'd0)
            $display("FAIL midrst_outputs got q_gray=%h q_bin=%h chg=%b err=%b vld=%b want all 0",
                     q_gray, q_bin, chg, gray_err, q_vld);
        else n_pass++;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_chk++;
            if (q_vld !== (i >= 3) || chg !== 2'b00 || gray_err !== 2'b00)
                $display("FAIL midrst_warm edge=%0d got vld=%b chg=%b err=%b want %b 00 00",
                         i, q_vld, chg, gray_err, (i >= 3));
            else n_pass++;
        end
        n_chk++;
        if (q_bin !== {4'd6, 4'd9}) $display("FAIL midrst_qbin got %h want 69", q_bin);
        else n_pass++;
        d_gray[3:0] = to_gray(4'd10);
        exp_q0.push_back(4'd10);
        tick(); tick(); tick();
        n_chk++;
        if (chg !== 2'b01) $display("FAIL midrst_live_chg got %b want 01", chg);
        else n_pass++;
        n_chk++;
        e = exp_q0.pop_front();
        if (q_bin[3:0] !== e) $display("FAIL midrst_live_qbin got %0d want %0d", q_bin[3:0], e);
        else n_pass++;
    endtask

    task automatic test_simultaneous;
        logic [3:0] e;
        d_gray = {4'b0100, to_gray(4'd11)};
        exp_q0.push_back(4'd11);
        exp_q1.push_back(4'd7);
        tick(); tick(); tick();
        n_chk++;
        if (chg !== 2'b11 || gray_err !== 2'b00)
            $display("FAIL simul_chg got chg=%b err=%b want 11 00", chg, gray_err);
        else n_pass++;
        n_chk++;
        e = exp_q0.pop_front();
        if (q_bin[3:0] !== e) $display("FAIL simul_qbin0 got %0d want %0d", q_bin[3:0], e);
        else n_pass++;
        n_chk++;
        e = exp_q1.pop_front();
        if (q_bin[7:4] !== e) $display("FAIL simul_qbin1 got %0d want %0d", q_bin[7:4], e);
        else n_pass++;
        tick();
        n_chk++;
        if (chg !== 2'b00) $display("FAIL simul_chg_low got %b want 00", chg);
        else n_pass++;
        n_chk++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0)
            $display("FAIL scoreboard_drain got q0=%0d q1=%0d want 0 0", exp_q0.size(), exp_q1.size());
        else n_pass++;
    endtask

    initial begin
        rst     = 1'b1;
        err_clr = 1'b0;
        d_gray  = 8'h00;
        test_reset();
        test_latency();
        test_wrap();
        test_illegal();
        test_mid_reset();
        test_simultaneous();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
